// File: rtl/btn_step_gen_if.sv
// Button-side signal bundle for btn_step_gen: raw button in, step/debounced level/step count out.
// master drives the button and observes the outputs; slave is the generator itself.
interface btn_step_gen_if;
  logic       btn_in;
  logic       step;
  logic       btn_db;
  logic [7:0] step_cnt;

  modport master (output btn_in, input step, btn_db, step_cnt);
  modport slave  (input btn_in, output step, btn_db, step_cnt);
endinterface

// File: rtl/btn_step_gen.sv
// Debounced push-button step generator: 2-flop synchroniser, counter-qualified debounce FSM,
// single-cycle step pulse and wrapping step count. Define BTN_AUTOREPEAT_EN to enable auto-repeat.
module btn_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic          clk,
  input  logic          rst,
  btn_step_gen_if.slave bus
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_step_gen: all cycle parameters must be >= 2");
  end

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            sync1_q, sync2_q;
  logic            btn_db_q, btn_db_d;
  logic            step_q, step_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic            press_step;
  logic            rpt_fire;

  // NOTE: every flop here uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      btn_db_q   <= 1'b0;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      btn_db_q   <= btn_db_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    btn_db_d   = btn_db_q;
    press_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          btn_db_d   = 1'b1;
          press_step = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d  = REL_WAIT;
          db_cnt_d = '0;
        end
      end
      REL_WAIT: begin
        if (sync2_q) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
          btn_db_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0] rpt_last;
  logic             rpt_first_q, rpt_first_d;

  // The first interval after entering HELD is HOLD_CYCLES, later ones REPEAT_CYCLES.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_fire    = 1'b0;
    rpt_last    = rpt_first_q ? RPT_W'(HOLD_CYCLES - 1) : RPT_W'(REPEAT_CYCLES - 1);
    if (state_q == HELD) begin
      if (rpt_cnt_q == rpt_last) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + 1'b1;
        rpt_first_d = rpt_first_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Press steps only occur in PRESS_WAIT and repeats only in HELD, so they never collide.
  assign step_d     = press_step | rpt_fire;
  assign step_cnt_d = step_d ? step_cnt_q + 8'd1 : step_cnt_q;

  assign bus.step     = step_q;
  assign bus.btn_db   = btn_db_q;
  assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Scoreboard bench for btn_step_gen: a behavioural run-length model predicts steps and levels,
// a negedge monitor compares the DUT against it.
module tb_btn_step_gen;
  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_step_gen_if bif ();

  btn_step_gen #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    int edge_no;
    int cnt;
    bit db;
  } step_ev_t;

  step_ev_t exp_q[$];
  int total  = 0;
  int passed = 0;
  int edge_no = 0;
  int step_seen = 0;
  bit prev_step = 1'b0;

  // Model state: button two samples late, debounced level, run of disagreeing samples,
  // consecutive edges spent held, step count.
  bit m_s1, m_s2, m_db;
  int m_run, m_k, m_cnt;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  initial begin
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_k = 0; m_cnt = 0;
    forever begin : model
      bit s, held_pre, press, fire;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_k = 0; m_cnt = 0;
        exp_q.delete();
      end else begin
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = bif.btn_in;
        held_pre = m_db && (m_run == 0);
        press = 0;
        fire  = 0;
        if (s != m_db) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
          m_db  = !m_db;
          m_run = 0;
          press = m_db;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (held_pre) begin
          m_k++;
          fire = (m_k == H) || (m_k > H && ((m_k - H) % R) == 0);
        end else begin
          m_k = 0;
        end
`else
        if (held_pre) m_k++;
        else m_k = 0;
`endif
        edge_no++;
        if (press || fire) begin
          m_cnt = (m_cnt + 1) % 256;
          exp_q.push_back('{edge_no, m_cnt, m_db});
        end
      end
    end
  end

  initial begin
    forever begin : monitor
      step_ev_t ev;
      @(negedge clk);
      if (!rst) begin
        check("btn_db", int'(bif.btn_db), int'(m_db));
        check("step_cnt", int'(bif.step_cnt), m_cnt);
        if (bif.step) begin
          step_seen++;
          check("step_back_to_back", int'(prev_step), 0);
          if (exp_q.size() == 0) begin
            check("step_unexpected", int'(bif.step), 0);
          end else begin
            ev = exp_q.pop_front();
            check("step_edge", edge_no, ev.edge_no);
            check("step_cnt_at_step", int'(bif.step_cnt), ev.cnt);
            check("btn_db_at_step", int'(bif.btn_db), int'(ev.db));
          end
        end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_no) begin
          check("step_missing", int'(bif.step), 1);
          ev = exp_q.pop_front();
        end
      end
      prev_step = bif.step;
    end
  end

  // Called at posedge+2: hold the button at v for n clock edges.
  task automatic hold(input bit v, input int n);
    bif.btn_in = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_step", int'(bif.step), 0);
    check("rst_btn_db", int'(bif.btn_db), 0);
    check("rst_step_cnt", int'(bif.step_cnt), 0);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
  endtask

  initial begin
    int base;
    bif.btn_in = 1'b0;
    @(posedge clk);
    #2;
    do_reset();
    hold(0, 4);

    // Clean press then release
    base = step_seen;
    hold(1, 10);
    hold(0, 12);
    check("clean_steps", step_seen - base, 1);
    check("clean_cnt", int'(bif.step_cnt), 1);

    // Press bounce
    base = step_seen;
    for (int i = 0; i < 5; i++) begin
      hold(1, 2);
      hold(0, 1);
    end
    hold(1, 10);
    check("bounce_steps", step_seen - base, 1);
    check("bounce_db", int'(bif.btn_db), 1);

    // Release bounce from HELD
    for (int i = 0; i < 5; i++) hold(i % 2, 2);
    hold(0, 12);
    check("relbounce_db", int'(bif.btn_db), 0);

    // Auto-repeat stimulus from a clean count
    @(posedge clk);
    #2;
    do_reset();
    hold(0, 3);
    base = step_seen;
    hold(1, 22);
    hold(0, 12);
`ifdef BTN_AUTOREPEAT_EN
    check("repeat_steps", step_seen - base, 5);
    check("repeat_cnt", int'(bif.step_cnt), 5);
`else
    check("repeat_steps", step_seen - base, 1);
    check("repeat_cnt", int'(bif.step_cnt), 1);
`endif

    // Reset mid-hold with step_cnt at 3
    do_reset();
    hold(0, 3);
    for (int i = 0; i < 3; i++) begin
      hold(1, 7);
      hold(0, 7);
    end
    check("pre_rst_cnt", int'(bif.step_cnt), 3);
    hold(1, 7);
    check("pre_rst_db", int'(bif.btn_db), 1);
    base = step_seen;
    do_reset();
    hold(1, 7);
    hold(0, 10);
    check("post_rst_steps", step_seen - base, 1);
    check("post_rst_cnt", int'(bif.step_cnt), 1);

    // Random bouncy activity
    for (int i = 0; i < 60; i++) hold(bit'($urandom_range(0, 1)), $urandom_range(1, 12));
    hold(0, 12);

    // Wrap after 256 clean presses
    do_reset();
    hold(0, 3);
    base = step_seen;
    for (int i = 0; i < 256; i++) begin
      hold(1, 6);
      hold(0, 7);
    end
    check("wrap_steps", step_seen - base, 256);
    check("wrap_cnt", int'(bif.step_cnt), 0);

    hold(0, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
